// File: rtl/tbird_pkg.sv
// Shared definitions for the turn-signal command generator and the tail-light
// sequencer: controller state encoding and default timing constants.
package tbird_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEFT    = 3'd1,
        RIGHT   = 3'd2,
        HAZARD  = 3'd3,
        LOCKOUT = 3'd4
    } ctrlState_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_CANCEL_CYCLES   = 64;

    function automatic logic isTurn(input ctrlState_t s);
        return (s == LEFT) || (s == RIGHT);
    endfunction

endpackage

// File: rtl/turn_signal_ctrl_switch_debounce.sv
// Two-flop synchroniser followed by a stability counter; the debounced level
// only follows the synchronised input after DEBOUNCE_CYCLES consecutive mismatches.
module switch_debounce
    import tbird_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset_b,
    input  logic raw,
    output logic debounced
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          syncMeta;
    logic          syncOut;
    logic [CW-1:0] stableCnt;

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            syncMeta  <= 1'b0;
            syncOut   <= 1'b0;
            stableCnt <= '0;
            debounced <= 1'b0;
        end else begin
            syncMeta <= raw;
            syncOut  <= syncMeta;
            // Any cycle where the input agrees with the held level restarts the count.
            if (syncOut == debounced) begin
                stableCnt <= '0;
            end else if (stableCnt == CNT_LAST) begin
                debounced <= syncOut;
                stableCnt <= '0;
            end else begin
                stableCnt <= stableCnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/turn_signal_ctrl.sv
// Turn-signal command generator: debounces stalk/hazard inputs and drives the
// InL/InR/InH request levels for the tail-light sequencer.
module turn_signal_ctrl
    import tbird_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CANCEL_CYCLES   = DEFAULT_CANCEL_CYCLES,
    parameter int CNT_W           = $clog2(CANCEL_CYCLES)
) (
    input  logic       clock,
    input  logic       reset_b,
    input  logic       sw_left,
    input  logic       sw_right,
    input  logic       btn_hazard,
    output logic       InL,
    output logic       InR,
    output logic       InH,
    output logic [2:0] state,
    output logic       conflict
);

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(CANCEL_CYCLES - 1);

    logic             dL;
    logic             dR;
    logic             dH;
    logic             hzPrev;
    logic             hzEdge;
    logic             pairLatched;
    logic             conflictNext;
    logic [CNT_W-1:0] turnTimer;
    ctrlState_t       curState;
    ctrlState_t       nextState;

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebLeft (
        .clock     (clock),
        .reset_b   (reset_b),
        .raw       (sw_left),
        .debounced (dL)
    );

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebRight (
        .clock     (clock),
        .reset_b   (reset_b),
        .raw       (sw_right),
        .debounced (dR)
    );

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebHazard (
        .clock     (clock),
        .reset_b   (reset_b),
        .raw       (btn_hazard),
        .debounced (dH)
    );

    assign hzEdge = dH & ~hzPrev;
    assign state  = curState;

    always_comb begin
        nextState    = curState;
        conflictNext = 1'b0;
        case (curState)
            IDLE: begin
                if (hzEdge) begin
                    nextState = HAZARD;
                end else if (dL && !dR) begin
                    nextState = LEFT;
                end else if (dR && !dL) begin
                    nextState = RIGHT;
                end else if (dL && dR && !pairLatched) begin
                    conflictNext = 1'b1;
                end
            end
            LEFT: begin
                if (hzEdge) begin
                    nextState = HAZARD;
                end else if (!dL) begin
                    nextState = IDLE;
                end else if (dR) begin
                    nextState    = IDLE;
                    conflictNext = 1'b1;
                end else if (turnTimer == TIMER_LAST) begin
                    nextState = LOCKOUT;
                end
            end
            RIGHT: begin
                if (hzEdge) begin
                    nextState = HAZARD;
                end else if (!dR) begin
                    nextState = IDLE;
                end else if (dL) begin
                    nextState    = IDLE;
                    conflictNext = 1'b1;
                end else if (turnTimer == TIMER_LAST) begin
                    nextState = LOCKOUT;
                end
            end
            HAZARD: begin
                if (hzEdge) begin
                    nextState = IDLE;
                end
            end
            LOCKOUT: begin
                if (hzEdge) begin
                    nextState = HAZARD;
                end else if (!dL && !dR) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Request outputs decode the next state so they share the state register's edge.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            curState    <= IDLE;
            InL         <= 1'b0;
            InR         <= 1'b0;
            InH         <= 1'b0;
            conflict    <= 1'b0;
            hzPrev      <= 1'b0;
            pairLatched <= 1'b0;
            turnTimer   <= '0;
        end else begin
            curState    <= nextState;
            InL         <= (nextState == LEFT);
            InR         <= (nextState == RIGHT);
            InH         <= (nextState == HAZARD);
            conflict    <= conflictNext;
            hzPrev      <= dH;
            // Suppresses repeat conflict pulses until the pair is released.
            pairLatched <= dL & dR & (pairLatched | conflictNext);
            if (isTurn(nextState) && (nextState == curState)) begin
                turnTimer <= turnTimer + CNT_W'(1);
            end else begin
                turnTimer <= '0;
            end
        end
    end

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Directed bench for turn_signal_ctrl with DEBOUNCE_CYCLES=4, CANCEL_CYCLES=16.
module tb_turn_signal_ctrl;
    import tbird_pkg::*;

    logic       clock;
    logic       reset_b;
    logic       sw_left;
    logic       sw_right;
    logic       btn_hazard;
    logic       InL;
    logic       InR;
    logic       InH;
    logic [2:0] state;
    logic       conflict;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       sL;
        logic       sR;
        logic       bH;
        int         n;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];

    turn_signal_ctrl #(.DEBOUNCE_CYCLES(4), .CANCEL_CYCLES(16)) dut (
        .clock      (clock),
        .reset_b    (reset_b),
        .sw_left    (sw_left),
        .sw_right   (sw_right),
        .btn_hazard (btn_hazard),
        .InL        (InL),
        .InR        (InR),
        .InH        (InH),
        .state      (state),
        .conflict   (conflict)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] mk(input logic l, input logic r, input logic h,
                                      input logic c, input logic [2:0] s);
        return {l, r, h, c, s};
    endfunction

    function automatic void addVec(input logic sL, input logic sR, input logic bH,
                                   input int n, input logic [6:0] exp);
        vec_t v;
        v.sL = sL; v.sR = sR; v.bH = bH; v.n = n; v.exp = exp;
        vecs.push_back(v);
    endfunction

    always @(negedge clock) begin
        if (reset_b) begin
            total++;
            if ((32'(InL) + 32'(InR) + 32'(InH)) > 1) begin
                bad++;
                $display("FAIL onehot: got InL=%0b InR=%0b InH=%0b expected at most one", InL, InR, InH);
            end
        end
    end

    initial begin
        int hiCount;

        // Sequence continues from LOCKOUT with sw_left held and fully debounced.
        addVec(0, 0, 0, 6,  mk(0, 0, 0, 0, 3'd4));
        addVec(0, 0, 0, 1,  mk(0, 0, 0, 0, 3'd0));
        addVec(1, 0, 0, 6,  mk(0, 0, 0, 0, 3'd0));
        addVec(1, 0, 0, 1,  mk(1, 0, 0, 0, 3'd1));
        addVec(0, 0, 0, 6,  mk(1, 0, 0, 0, 3'd1));
        addVec(0, 0, 0, 1,  mk(0, 0, 0, 0, 3'd0));
        addVec(0, 1, 0, 3,  mk(0, 0, 0, 0, 3'd0));
        addVec(0, 0, 0, 10, mk(0, 0, 0, 0, 3'd0));
        addVec(0, 1, 0, 6,  mk(0, 0, 0, 0, 3'd0));
        addVec(0, 1, 0, 1,  mk(0, 1, 0, 0, 3'd2));
        addVec(0, 0, 0, 6,  mk(0, 1, 0, 0, 3'd2));
        addVec(0, 0, 0, 1,  mk(0, 0, 0, 0, 3'd0));
        addVec(1, 1, 0, 6,  mk(0, 0, 0, 0, 3'd0));
        addVec(1, 1, 0, 1,  mk(0, 0, 0, 1, 3'd0));
        addVec(1, 1, 0, 1,  mk(0, 0, 0, 0, 3'd0));
        addVec(1, 1, 0, 5,  mk(0, 0, 0, 0, 3'd0));
        addVec(1, 0, 0, 7,  mk(1, 0, 0, 0, 3'd1));
        addVec(1, 1, 0, 6,  mk(1, 0, 0, 0, 3'd1));
        addVec(1, 1, 0, 1,  mk(0, 0, 0, 1, 3'd0));
        addVec(1, 1, 0, 1,  mk(0, 0, 0, 0, 3'd0));
        addVec(0, 0, 0, 8,  mk(0, 0, 0, 0, 3'd0));
        addVec(0, 1, 0, 7,  mk(0, 1, 0, 0, 3'd2));
        addVec(0, 1, 1, 6,  mk(0, 1, 0, 0, 3'd2));
        addVec(0, 1, 0, 1,  mk(0, 0, 1, 0, 3'd3));
        addVec(0, 1, 0, 10, mk(0, 0, 1, 0, 3'd3));
        addVec(0, 1, 1, 6,  mk(0, 0, 1, 0, 3'd3));
        addVec(0, 1, 0, 1,  mk(0, 0, 0, 0, 3'd0));
        addVec(0, 1, 0, 1,  mk(0, 1, 0, 0, 3'd2));

        reset_b    = 1'b0;
        sw_left    = 1'b1;
        sw_right   = 1'b0;
        btn_hazard = 1'b0;
        tick(3);
        check("resetHold", {InL, InR, InH, conflict, state}, mk(0, 0, 0, 0, 3'd0));

        reset_b = 1'b1;
        tick(6);
        check("releaseEdge6", {InL, state}, {1'b0, 3'd0});
        tick(1);
        check("releaseEdge7", {InL, state}, {1'b1, 3'd1});

        hiCount = 1;
        for (int i = 0; i < 40 && InL; i++) begin
            tick(1);
            if (InL) hiCount++;
        end
        check("cancelHighCycles", hiCount, 16);
        check("lockoutState", {InL, InR, InH, state}, {3'b000, 3'd4});

        for (int v = 0; v < vecs.size(); v++) begin
            sw_left    = vecs[v].sL;
            sw_right   = vecs[v].sR;
            btn_hazard = vecs[v].bH;
            tick(vecs[v].n);
            check($sformatf("vec%0d", v), {InL, InR, InH, conflict, state}, vecs[v].exp);
        end

        // Let the hazard debounce settle low, then release right and press hazard together.
        tick(6);
        check("rightBeforeSimul", {InR, state}, {1'b1, 3'd2});
        sw_right   = 1'b0;
        btn_hazard = 1'b1;
        tick(6);
        btn_hazard = 1'b0;
        tick(1);
        check("hazardWinsSimul", {InL, InR, InH, state}, {3'b001, 3'd3});
        tick(10);
        check("hazardHeld", {InH, state}, {1'b1, 3'd3});

        #2 reset_b = 1'b0;
        #1;
        check("asyncResetMidHazard", {InL, InR, InH, conflict, state}, mk(0, 0, 0, 0, 3'd0));
        #2 reset_b = 1'b1;
        tick(20);
        check("noHazardRelatch", {InL, InR, InH, conflict, state}, mk(0, 0, 0, 0, 3'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
